// File: rtl/tlk2711_pkg.sv
// Shared constants and types for the TLK2711 TX test-pattern generator.
package tlk2711_pkg;

  // TX mode value that selects the long line-mode frame.
  localparam logic [2:0]  MODE_LINE      = 3'd3;

  // Pattern words per frame (byte counts divided by two).
  localparam int unsigned NORM_LEN       = 434;
  localparam int unsigned LINE_LEN       = 5376;
  localparam int unsigned GAP_CYCLES_DEF = 4;

  // Pattern sequence understood by the downstream FIFO checker.
  localparam logic [15:0] PAT_SEED       = 16'h0001;
  localparam logic [15:0] PAT_STEP       = 16'h0202;

  // Marker in the top lane of the tail word.
  localparam logic [15:0] TAIL_MARK      = 16'hBC5C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    TAIL = 2'd2,
    GAP  = 2'd3
  } state_t;

endpackage : tlk2711_pkg

// File: rtl/tlk2711_tx_pattern_gen.sv
// TLK2711 TX test-pattern source. Emits framed 64-bit words (pattern words
// followed by one tail word) into the TX FIFO with a valid/ready handshake.
// Optional build macro TX_PATTERN_ERR_INJ_EN adds i_err_inject, which flips
// bit 0 of one pattern word so the checker can be shown to catch it.
module tlk2711_tx_pattern_gen
  import tlk2711_pkg::*;
#(
  parameter int unsigned FRAME_NORM = NORM_LEN,
  parameter int unsigned FRAME_LINE = LINE_LEN,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter logic [15:0] SEED       = PAT_SEED,
  parameter logic [15:0] STEP       = PAT_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_soft_rst,
  input  logic        i_tx_start,
  input  logic [2:0]  i_tx_mode,
  input  logic [15:0] i_frame_num,
  input  logic        i_tx_stop,
  input  logic        i_ready,
`ifdef TX_PATTERN_ERR_INJ_EN
  input  logic        i_err_inject,
`endif
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_pat, w_pat_nxt;
  logic [15:0] r_frame_len, w_frame_len_nxt;
  logic [15:0] r_frame_num, w_frame_num_nxt;
  logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [7:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic        r_stop_seen, w_stop_seen_nxt;
  logic        r_start_d;
  logic        r_valid, r_frame_done;
  logic [63:0] r_data;
  logic        w_valid_nxt;
  logic [63:0] w_data_nxt;
  logic        w_done;
  logic        w_rst, w_start_edge, w_xfer, w_stop_any;
  logic [15:0] w_fcnt_inc;
  logic        w_err_flip;

  assign w_rst        = rst | i_soft_rst;
  assign w_start_edge = i_tx_start & ~r_start_d;
  assign w_xfer       = r_valid & i_ready;
  assign w_stop_any   = r_stop_seen | i_tx_stop;
  assign w_fcnt_inc   = (r_frame_cnt == 16'hFFFF) ? r_frame_cnt : r_frame_cnt + 16'd1;

  // Delayed copy of the start level for rising-edge detection.
  // NOTE: left unreset on purpose so a start level held through reset is not
  // mistaken for a fresh edge once reset releases.
  always_ff @(posedge clk) begin
    r_start_d <= i_tx_start;
  end

  // Next-state and counter updates for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pat_nxt       = r_pat;
    w_frame_len_nxt = r_frame_len;
    w_frame_num_nxt = r_frame_num;
    w_frame_cnt_nxt = r_frame_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_stop_seen_nxt = r_stop_seen;
    w_done          = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_state_nxt     = SEND;
          w_cnt_nxt       = '0;
          w_pat_nxt       = SEED;
          w_frame_cnt_nxt = '0;
          w_stop_seen_nxt = 1'b0;
          w_frame_len_nxt = (i_tx_mode == MODE_LINE) ? 16'(FRAME_LINE) : 16'(FRAME_NORM);
          w_frame_num_nxt = i_frame_num;
        end
      end

      SEND: begin
        w_stop_seen_nxt = w_stop_any;
        if (w_xfer) begin
          w_cnt_nxt = r_cnt + 16'd1;
          w_pat_nxt = r_pat + STEP;
          if (r_cnt == r_frame_len - 16'd1) begin
            w_state_nxt = TAIL;
          end
        end
      end

      TAIL: begin
        w_stop_seen_nxt = w_stop_any;
        if (w_xfer) begin
          w_done          = 1'b1;
          w_frame_cnt_nxt = w_fcnt_inc;
          w_cnt_nxt       = '0;
          w_pat_nxt       = SEED;
          w_gap_cnt_nxt   = '0;
          w_stop_seen_nxt = 1'b0;
          if (w_stop_any || ((r_frame_num != 16'd0) && (w_fcnt_inc == r_frame_num))) begin
            w_state_nxt = IDLE;
          end else if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
          end else begin
            w_state_nxt = SEND;
          end
        end
      end

      GAP: begin
        if (w_stop_any) begin
          w_state_nxt = IDLE;
        end else if (r_gap_cnt == 8'(GAP_CYCLES - 1)) begin
          w_state_nxt = SEND;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 8'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef TX_PATTERN_ERR_INJ_EN
  logic r_err_arm, w_err_arm_nxt, w_load;

  // Arm on a pulse; spend the arm on the next freshly loaded pattern word so a
  // word already held under backpressure never changes.
  always_comb begin
    w_load        = (w_state_nxt == SEND) && ((r_state != SEND) || w_xfer);
    w_err_flip    = w_load && (r_err_arm || i_err_inject);
    w_err_arm_nxt = w_err_flip ? 1'b0 : (r_err_arm | i_err_inject);
  end

  // Single-shot error-injection flag.
  always_ff @(posedge clk) begin
    if (w_rst) r_err_arm <= 1'b0;
    else       r_err_arm <= w_err_arm_nxt;
  end
`else
  assign w_err_flip = 1'b0;
`endif

  // Output word is built from next-state values so o_valid/o_data are flops
  // and stay frozen whenever the sequencer does not advance.
  always_comb begin
    w_valid_nxt = (w_state_nxt == SEND) || (w_state_nxt == TAIL);
    w_data_nxt  = '0;
    if (w_state_nxt == SEND) begin
      w_data_nxt = {4{w_pat_nxt}} ^ {63'd0, w_err_flip};
    end else if (w_state_nxt == TAIL) begin
      w_data_nxt = {TAIL_MARK, w_frame_cnt_nxt, 32'h0};
    end
  end

  // State, counters and registered outputs; either reset aborts immediately.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (w_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pat        <= SEED;
      r_frame_len  <= 16'(FRAME_NORM);
      r_frame_num  <= '0;
      r_frame_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_stop_seen  <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pat        <= w_pat_nxt;
      r_frame_len  <= w_frame_len_nxt;
      r_frame_num  <= w_frame_num_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_stop_seen  <= w_stop_seen_nxt;
      r_valid      <= w_valid_nxt;
      r_data       <= w_data_nxt;
      r_frame_done <= w_done;
    end
  end

  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_busy       = (r_state != IDLE);

endmodule : tlk2711_tx_pattern_gen
